// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg: shared direction constants and the saturation build switch.
// Defining UP_DOWN_COUNTER_SAT_EN turns modulo wrap into saturation at the limits.
package up_down_counter_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
`ifdef UP_DOWN_COUNTER_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif
endpackage

// File: rtl/up_down_counter_next.sv
// up_down_counter_next: next-count logic with limit detection for either direction.
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  input  logic         dir,
  input  logic         sat,
  output logic [N-1:0] nxt,
  output logic         lim
);
  localparam logic [N-1:0] max_q = '1;
  always_comb begin
    lim = (dir == DIR_UP) ? (q == max_q) : (q == '0);
    nxt = (lim && sat) ? q : ((dir == DIR_UP) ? q + 1'b1 : q - 1'b1);
  end
endmodule

// File: rtl/up_down_counter.sv
// up_down_counter: N-bit up/down counter, async active-low reset, registered wrap pulse.
// Build with UP_DOWN_COUNTER_SAT_EN to saturate at the limits instead of wrapping.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mod,
  output logic [N-1:0] q,
  output logic         wrap
);
  logic [N-1:0] nxt;
  logic         lim;
  up_down_counter_next #(.N(N)) u_next (
    .q   (q),
    .dir (mod),
    .sat (SAT_EN),
    .nxt (nxt),
    .lim (lim)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= nxt;
      wrap <= lim;
    end
  end
`ifndef SYNTHESIS
  // An unknown direction would silently corrupt the count.
  always @(posedge clk) begin
    if (rst) assert (!$isunknown(mod)) else $error("mod is X/Z while counting");
  end
`endif
endmodule

// File: tb/tb_up_down_counter.sv
// tb_up_down_counter: directed checks of reset, wrap/saturation, reversal and async reset.
module tb_up_down_counter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mod = 1'b0;
  logic [2:0] q;
  logic       wrap;
  int         n_chk = 0;
  int         n_fail = 0;

  up_down_counter #(.N(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .mod  (mod),
    .q    (q),
    .wrap (wrap)
  );

  always #10 clk = ~clk;

  task automatic chk(input logic [2:0] eq, input logic ew, input string tag);
    n_chk++;
    assert (q === eq) else begin
      n_fail++;
      $error("FAIL %s q: got %0d want %0d", tag, q, eq);
    end
    n_chk++;
    assert (wrap === ew) else begin
      n_fail++;
      $error("FAIL %s wrap: got %0b want %0b", tag, wrap, ew);
    end
  endtask

  task automatic tick(input logic [2:0] eq, input logic ew, input string tag);
    @(negedge clk);
    chk(eq, ew, tag);
  endtask

  initial begin
    #1 rst = 1'b0;
    #4 chk(0, 0, "reset_async");
    @(negedge clk);
    chk(0, 0, "reset_hold");
    #5 rst = 1'b1;
`ifdef UP_DOWN_COUNTER_SAT_EN
    tick(0, 1, "sat_down_block0");
    tick(0, 1, "sat_down_block1");
    mod = 1'b1;
    tick(1, 0, "up1");
    tick(2, 0, "up2");
    tick(3, 0, "up3");
    tick(4, 0, "up4");
    tick(5, 0, "up5");
    tick(6, 0, "up6");
    tick(7, 0, "up7");
    tick(7, 1, "sat_up_block0");
    tick(7, 1, "sat_up_block1");
    mod = 1'b0;
    tick(6, 0, "dn6");
    tick(5, 0, "dn5");
    tick(4, 0, "dn4");
    tick(3, 0, "dn3");
    tick(2, 0, "dn2");
    tick(1, 0, "dn1");
    tick(0, 0, "dn0");
    tick(0, 1, "sat_down_block2");
    mod = 1'b1;
    tick(1, 0, "rev_up1");
    tick(2, 0, "up2b");
    tick(3, 0, "up3b");
    tick(4, 0, "up4b");
    tick(5, 0, "up5b");
`else
    tick(7, 1, "release_wrap");
    tick(6, 0, "dn6");
    tick(5, 0, "dn5");
    tick(4, 0, "dn4");
    tick(3, 0, "dn3");
    mod = 1'b1;
    tick(4, 0, "dir_up4");
    tick(5, 0, "dir_up5");
    mod = 1'b0;
    tick(4, 0, "dir_dn4");
    tick(3, 0, "dir_dn3");
    tick(2, 0, "dn2");
    tick(1, 0, "dn1");
    tick(0, 0, "dn0");
    tick(7, 1, "down_wrap");
    tick(6, 0, "after_down_wrap");
    mod = 1'b1;
    tick(7, 0, "up7");
    tick(0, 1, "up_wrap");
    tick(1, 0, "after_up_wrap");
    mod = 1'b0;
    tick(0, 0, "dn_to0");
    mod = 1'b1;
    tick(1, 0, "rev_at0_no_wrap");
    tick(2, 0, "up2");
    tick(3, 0, "up3");
    tick(4, 0, "up4");
    tick(5, 0, "up5");
`endif
    #3 rst = 1'b0;
    #1 chk(0, 0, "midcount_async_reset");
    tick(0, 0, "midcount_hold0");
    tick(0, 0, "midcount_hold1");
    rst = 1'b1;
    tick(1, 0, "resume_up");
    tick(2, 0, "resume_up2");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/up_down_counter.md
Name: up_down_counter

Overview:
- Parameterised N-bit synchronous binary up/down counter with an asynchronous active-low reset.
- Direction is selected every cycle by a single mode input.
- Used as a generic counting primitive: address/tick generation and bidirectional position tracking.
- Default behaviour is modulo-2^N wrap-around; saturation is available as a compile option.

Parameters:
- N, default 4, counter width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, regardless of clk).
- mod  input  1  direction select: 1 = count up, 0 = count down.
- q    output N  current count, registered.
- wrap output 1  registered one-cycle pulse, high in the cycle after q wrapped (or hit a limit in saturating mode).

Behaviour:
- Reset:
  - While rst=0: q=0 and wrap=0, asynchronously on rst falling edge, held until release.
  - Counting resumes on the first rising clk edge with rst=1.
  - Reset mid-count discards the current value with no delay.
- Each rising clk edge with rst=1:
  - mod=1: q <= q+1 mod 2^N.
  - mod=0: q <= q-1 mod 2^N.
- There is no enable; q changes on every edge out of reset.
- Latency:
  - mod is sampled at the clock edge; a direction change takes effect on that same edge.
  - No pipeline stage; q is the register output, with no combinational path from mod to q.
- Wrap-around:
  - Up from 2^N-1 goes to 0.
  - Down from 0 goes to 2^N-1.
  - wrap=1 for exactly the cycle following such an edge; otherwise wrap=0.
- Direction reversal at a boundary (e.g. q=0 and mod switches to 1): plain increment, no wrap.
- Arithmetic: unsigned, N bits; the carry/borrow out is used only for wrap detection.
- No X propagation: mod=X is treated as an illegal input; optional simulation assertion flags it when rst=1.

Optional Feature:
- Macro: UP_DOWN_COUNTER_SAT_EN.
- Defined:
  - Counter saturates: up at 2^N-1 holds 2^N-1; down at 0 holds 0.
  - wrap pulses for one cycle on each edge where a limit blocked the count.
  - All other behaviour is unchanged.
- Undefined: modulo wrap-around as described above.

Decomposition:
- Package up_down_counter_pkg holds:
  - DIR_UP=1'b1 and DIR_DOWN=1'b0 direction constants.
  - A function next_count(q, dir, sat) returning the next value plus a wrap/limit flag, sized by N.
- No sub-module needed: the block is a single register plus next-state logic.
- A small up_down_counter_next combinational sub-module is acceptable if the function form is not used.

Test Plan (N=3, clk period 20):
- Reset: hold rst=0 for 20, mod=0 → q=0, wrap=0 during reset. Release → first edge q=7 with wrap=1 next cycle, then 6, 5, 4, …
- Down wrap: mod=0 from q=1 → q sequence 1, 0, 7, 6; wrap high one cycle after the 0→7 edge only.
- Up wrap: mod=1 from q=6 → 6, 7, 0, 1; wrap high one cycle after 7→0 only.
- Direction change: count down to q=3, toggle mod to 1 → next edges 4, 5; toggle back to 0 → 4, 3. No wrap pulses.
- Async reset mid-count: assert rst=0 between clock edges at q=5 → q=0 immediately, before the next edge; stays 0 until release.
- With UP_DOWN_COUNTER_SAT_EN:
  - mod=1 from q=6 gives 6, 7, 7, 7, with wrap high on each blocked edge.
  - mod=0 from q=1 gives 1, 0, 0.
